// File: rtl/filtro_pb_pkg.sv
// Shared helpers and default geometry for the oversampled-stream low-pass filter.
package filtro_pb_pkg;

  localparam int SAMPLES_DEF = 2;
  localparam int OSF_DEF     = 8;

  // Width needed to hold a count of 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ones_counter.sv
// Combinational population count built as a recursive balanced adder tree.
module ones_counter
  import filtro_pb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]              in,
  output logic [count_width(WIDTH)-1:0] count
);

  localparam int CW = count_width(WIDTH);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign count = in;
    end else begin : g_node
      localparam int LO   = WIDTH / 2;
      localparam int HI   = WIDTH - LO;
      localparam int CWLO = count_width(LO);
      localparam int CWHI = count_width(HI);

      logic [CWLO-1:0] cnt_lo;
      logic [CWHI-1:0] cnt_hi;

      ones_counter #(.WIDTH(LO)) u_lo (.in(in[LO-1:0]),     .count(cnt_lo));
      ones_counter #(.WIDTH(HI)) u_hi (.in(in[WIDTH-1:LO]), .count(cnt_hi));

      // Both halves fit in CW bits, and so does their sum (at most WIDTH).
      assign count = CW'(cnt_lo) + CW'(cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/filtro_pb.sv
// Majority/averaging filter: on each rising edge of P, register the ones-count of the window.
module filtro_pb
  import filtro_pb_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEF,
  parameter int OSF     = OSF_DEF,
  localparam int N      = SAMPLES * OSF,
  localparam int W      = count_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         P,
  input  logic [N-1:0] DataIn,
  output logic [W-1:0] DataOut,
  output logic         Valid
);

  logic         p_d;
  logic         rise;
  logic [W-1:0] cnt;

  ones_counter #(.WIDTH(N)) u_cnt (.in(DataIn), .count(cnt));

  assign rise = P & ~p_d;

  // p_d clears in reset so a strobe still held high afterwards is captured once.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_d     <= 1'b0;
      DataOut <= '0;
      Valid   <= 1'b0;
    end else begin
      p_d   <= P;
      Valid <= rise;
      if (rise) DataOut <= cnt;
    end
  end

endmodule

// File: tb/tb_filtro_pb.sv
// Self-checking bench for filtro_pb across four geometries, with a popcount reference model.
module tb_filtro_pb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic P   = 1'b0;

  logic [15:0] din0 = '0;
  logic [0:0]  din1 = '0;
  logic [11:0] din2 = '0;
  logic [31:0] din3 = '0;

  logic [4:0] out0;
  logic [0:0] out1;
  logic [3:0] out2;
  logic [5:0] out3;
  logic       v0, v1, v2, v3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  filtro_pb #(.SAMPLES(2), .OSF(8)) dut0 (.clk(clk), .rst(rst), .P(P), .DataIn(din0), .DataOut(out0), .Valid(v0));
  filtro_pb #(.SAMPLES(1), .OSF(1)) dut1 (.clk(clk), .rst(rst), .P(P), .DataIn(din1), .DataOut(out1), .Valid(v1));
  filtro_pb #(.SAMPLES(3), .OSF(4)) dut2 (.clk(clk), .rst(rst), .P(P), .DataIn(din2), .DataOut(out2), .Valid(v2));
  filtro_pb #(.SAMPLES(4), .OSF(8)) dut3 (.clk(clk), .rst(rst), .P(P), .DataIn(din3), .DataOut(out3), .Valid(v3));

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_x(input string name, input logic [31:0] act, input int exp);
    n_total++;
    if (!$isunknown(act) && int'(act) == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0d", name, act, exp);
  endtask

  // Reference model: a capture happens on an edge where P is high but was low
  // at the previous (non-reset) edge; the captured value is the number of ones.
  int exp_out[4];
  bit exp_v;
  bit p_last;
  bit model_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_out    = '{0, 0, 0, 0};
      exp_v      = 0;
      p_last     = 0;
      model_live = 1;
    end else begin
      exp_v = P && !p_last;
      if (exp_v) begin
        exp_out[0] = $countones(din0);
        exp_out[1] = $countones(din1);
        exp_out[2] = $countones(din2);
        exp_out[3] = $countones(din3);
      end
      p_last = P;
    end
    #1;
    if (model_live) begin
      check_x("m_out0", 32'(out0), exp_out[0]);
      check_x("m_out1", 32'(out1), exp_out[1]);
      check_x("m_out2", 32'(out2), exp_out[2]);
      check_x("m_out3", 32'(out3), exp_out[3]);
      check_x("m_valid0", 32'(v0), int'(exp_v));
      check_x("m_valid1", 32'(v1), int'(exp_v));
      check_x("m_valid2", 32'(v2), int'(exp_v));
      check_x("m_valid3", 32'(v3), int'(exp_v));
    end
  end

  // Drive inputs at a falling edge, then return at the next falling edge.
  task automatic cyc(input bit p, input logic [15:0] d);
    P    = p;
    din0 = d;
    din1 = 1'($urandom);
    din2 = 12'($urandom);
    din3 = $urandom;
    @(negedge clk);
  endtask

  int seq_in[5]  = '{12, 31, 2, 4, 14};
  int seq_exp[5] = '{2, 5, 1, 1, 3};
  int ext_in[3]  = '{16'h0000, 16'hFFFF, 16'h8001};
  int ext_exp[3] = '{0, 16, 2};

  initial begin
    int vcount;
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 16'hFFFF);
    cyc(1, 16'hFFFF);
    check("rst_out", int'(out0), 0);
    check("rst_valid", int'(v0), 0);
    rst = 1'b0;
    cyc(1, 16'hFFFF);
    check("post_rst_out", int'(out0), 16);
    check("post_rst_valid", int'(v0), 1);
    cyc(0, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      vcount = 0;
      for (int k = 0; k < 3; k++) begin
        cyc(1, 16'(seq_in[i]));
        vcount += int'(v0);
        if (k == 0) check("seq_out", int'(out0), seq_exp[i]);
      end
      for (int k = 0; k < 3; k++) begin
        cyc(0, 16'($urandom));
        vcount += int'(v0);
      end
      check("seq_hold", int'(out0), seq_exp[i]);
      check("seq_one_valid", vcount, 1);
    end

    cyc(1, 16'd12);
    check("hold_first", int'(out0), 2);
    cyc(1, 16'd31);
    check("hold_ignore", int'(out0), 2);
    check("hold_no_valid", int'(v0), 0);
    cyc(0, 16'd31);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'(ext_in[i]));
      check("extreme", int'(out0), ext_exp[i]);
      cyc(0, 16'(ext_in[i]));
    end

    cyc(1, 16'd31);
    check("mid_pre", int'(out0), 5);
    cyc(0, 16'd31);
    rst = 1'b1;
    cyc(0, 16'd31);
    check("mid_rst", int'(out0), 0);
    rst = 1'b0;
    cyc(0, 16'd14);
    cyc(1, 16'd14);
    check("mid_after", int'(out0), 3);
    cyc(0, 16'd14);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      cyc(($urandom_range(0, 2) != 0), 16'($urandom));
    end
    rst = 1'b0;
    cyc(0, 16'h0000);
    cyc(0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
